arb_mux: RTL

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux.sv | 130 +++++++++++++
 1 files changed

// File: rtl/arb_mux.sv
// arb_mux: NCH-channel valid/ready multiplexer with a single registered output
// stage. The channel is picked either directly by sel (mode=0) or by a
// round-robin search that starts after the last granted channel (mode=1).
// The output register reloads in the same cycle it drains, so a continuous
// stream moves one word per cycle.
module arb_mux #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [$clog2(NCH)-1:0]   sel,
  input  logic [NCH*WIDTH-1:0]     d,
  input  logic [NCH-1:0]           in_valid,
  output logic [NCH-1:0]           in_ready,
  output logic [WIDTH-1:0]         dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(NCH)-1:0]   grant,
  output logic [15:0]              xfer_cnt
);

  localparam int SW = $clog2(NCH);

  // Output stage and arbitration state
  logic [WIDTH-1:0] dout_r;
  logic             out_valid_r;
  logic [SW-1:0]    grant_r;
  logic [15:0]      xfer_cnt_r;
  logic [SW-1:0]    last_r;

  // Combinational selection
  logic             load_en_s;
  logic             out_xfer_s;
  logic [SW-1:0]    rr_idx_s;
  logic             rr_found_s;
  logic [SW-1:0]    rr_probe_s;
  logic [SW-1:0]    cand_idx_s;
  logic             cand_ok_s;
  logic             in_xfer_s;
  logic [WIDTH-1:0] cand_data_s;
  logic [NCH-1:0]   in_ready_s;

  // The output register may capture when it is empty or being drained now
  assign load_en_s  = !out_valid_r || out_ready;
  assign out_xfer_s = out_valid_r && out_ready;

  // Round-robin search: first valid channel after last_r, wrapping modulo NCH
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    rr_probe_s = '0;
    for (int k = 1; k <= NCH; k++) begin
      rr_probe_s = SW'((int'(last_r) + k) % NCH);
      if (!rr_found_s && in_valid[rr_probe_s]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = rr_probe_s;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Candidate channel: direct select (out-of-range sel means none) or round-robin
  always_comb begin
    cand_idx_s = '0;
    cand_ok_s  = 1'b0;
    if (mode) begin
      cand_idx_s = rr_idx_s;
      cand_ok_s  = rr_found_s;
    end else begin
      cand_idx_s = sel;
      cand_ok_s  = (int'(sel) < NCH);
    end
  end

  // A transfer needs a legal candidate that is valid and room in the output
  // register; ready is only raised toward a channel that actually offers data,
  // so a selected-but-idle channel sees ready low.
  assign in_xfer_s = cand_ok_s && load_en_s && !rst && in_valid[cand_idx_s];

  // Decode the accepting channel into one-hot in_ready and mux its data word
  always_comb begin
    in_ready_s  = '0;
    cand_data_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cand_idx_s == SW'(i)) begin
        in_ready_s[i] = in_xfer_s;
        cand_data_s   = d[i*WIDTH +: WIDTH];
      end else begin
        in_ready_s[i] = 1'b0;
      end
    end
  end

  // Output register, grant/last tracking and transfer counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r      <= '0;
      out_valid_r <= 1'b0;
      grant_r     <= '0;
      xfer_cnt_r  <= 16'h0000;
      last_r      <= SW'(NCH - 1);
    end else begin
      if (out_xfer_s) begin
        xfer_cnt_r <= xfer_cnt_r + 16'h0001;
      end else begin
        xfer_cnt_r <= xfer_cnt_r;
      end
      if (in_xfer_s) begin
        dout_r      <= cand_data_s;
        grant_r     <= cand_idx_s;
        out_valid_r <= 1'b1;
        last_r      <= cand_idx_s;
      end else if (out_xfer_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign dout      = dout_r;
  assign out_valid = out_valid_r;
  assign grant     = grant_r;
  assign xfer_cnt  = xfer_cnt_r;

endmodule
